// File: rtl/traffic_phase_scheduler_if.sv
// Detector/lamp bundle for traffic_phase_scheduler: the master drives the
// detectors and the slave (the scheduler) drives the lamps and status.
interface traffic_phase_scheduler_if;
  logic       car1_req;
  logic       car2_req;
  logic       ped_req;
  logic       Road1_G;
  logic       Road1_Y;
  logic       Road1_R;
  logic       Road2_G;
  logic       Road2_Y;
  logic       Road2_R;
  logic       Walk_G;
  logic       Walk_R;
  logic [2:0] phase;
  logic       ped_wait;

  modport master (
    output car1_req, car2_req, ped_req,
    input  Road1_G, Road1_Y, Road1_R, Road2_G, Road2_Y, Road2_R,
    input  Walk_G, Walk_R, phase, ped_wait
  );

  modport slave (
    input  car1_req, car2_req, ped_req,
    output Road1_G, Road1_Y, Road1_R, Road2_G, Road2_Y, Road2_R,
    output Walk_G, Walk_R, phase, ped_wait
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated round-robin phase scheduler (Road1 -> Road2 -> Walk) with registered lamps.
// Optional build macro PED_PRIORITY_EN: pending pedestrian demand preempts round-robin and cuts green at G_MIN.
module traffic_phase_scheduler #(
  parameter int G_MIN   = 10,
  parameter int G_MAX   = 40,
  parameter int Y_LEN   = 5,
  parameter int GAP_LEN = 2,
  parameter int WG_LEN  = 26,
  parameter int BLK_LEN = 6,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_phase_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    R1G   = 3'd1,
    R1Y   = 3'd2,
    R2G   = 3'd3,
    R2Y   = 3'd4,
    WALK  = 3'd5,
    BLINK = 3'd6,
    GAP   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] G_MIN_C   = CNT_W'(G_MIN);
  localparam logic [CNT_W-1:0] G_MAX_C   = CNT_W'(G_MAX);
  localparam logic [CNT_W-1:0] Y_LEN_C   = CNT_W'(Y_LEN);
  localparam logic [CNT_W-1:0] GAP_LEN_C = CNT_W'(GAP_LEN);
  localparam logic [CNT_W-1:0] WG_LEN_C  = CNT_W'(WG_LEN);
  localparam logic [CNT_W-1:0] BLK_LEN_C = CNT_W'(BLK_LEN);
  localparam logic [CNT_W-1:0] T_SAT_C   = (G_MAX > WG_LEN) ? G_MAX_C : WG_LEN_C;
  localparam logic [CNT_W-1:0] T_ONE_C   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  state_t           last;
  state_t           last_nxt;
  state_t           grant;
  logic [CNT_W-1:0] t;
  logic [CNT_W-1:0] t_nxt;
  logic             pend1;
  logic             pend2;
  logic             pendp;
  logic             pend1_nxt;
  logic             pend2_nxt;
  logic             pendp_nxt;
  logic             ped_cut;
  logic [7:0]       lamp;
  logic [7:0]       lamp_nxt;

  // First pending phase after the last granted one; IDLE when nothing waits.
  function automatic state_t arbitrate(input state_t last_g, input logic p1,
                                       input logic p2, input logic pp);
    state_t g;
    g = IDLE;
    case (last_g)
      R1G:     g = p2 ? R2G : (pp ? WALK : (p1 ? R1G : IDLE));
      R2G:     g = pp ? WALK : (p1 ? R1G : (p2 ? R2G : IDLE));
      default: g = p1 ? R1G : (p2 ? R2G : (pp ? WALK : IDLE));
    endcase
`ifdef PED_PRIORITY_EN
    if (pp) g = WALK;
`endif
    return g;
  endfunction

  function automatic logic green_done(input logic [CNT_W-1:0] tc, input logic other,
                                      input logic own);
    return (tc >= G_MIN_C) && other && (!own || (tc == G_MAX_C));
  endfunction

  // Lamp order: R1G R1Y R1R R2G R2Y R2R WG WR.
  function automatic logic [7:0] lamp_decode(input state_t s, input logic blink_on);
    logic [7:0] l;
    l = 8'b0010_0101;
    case (s)
      R1G:     l = 8'b1000_0101;
      R1Y:     l = 8'b0100_0101;
      R2G:     l = 8'b0011_0001;
      R2Y:     l = 8'b0010_1001;
      WALK:    l = 8'b0010_0110;
      BLINK:   l = {6'b001001, blink_on, 1'b0};
      default: l = 8'b0010_0101;
    endcase
    return l;
  endfunction

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    t_nxt     = (t >= T_SAT_C) ? t : t + T_ONE_C;
    grant     = arbitrate(last, pend1, pend2, pendp);
    ped_cut   = 1'b0;
`ifdef PED_PRIORITY_EN
    ped_cut   = pendp && (t >= G_MIN_C);
`endif
    case (state)
      IDLE:    if (grant != IDLE) state_nxt = grant;
      R1G:     if (green_done(t, pend2 | pendp, bus.car1_req) || ped_cut) state_nxt = R1Y;
      R1Y:     if (t == Y_LEN_C) state_nxt = GAP;
      R2G:     if (green_done(t, pend1 | pendp, bus.car2_req) || ped_cut) state_nxt = R2Y;
      R2Y:     if (t == Y_LEN_C) state_nxt = GAP;
      WALK:    if (t == WG_LEN_C) state_nxt = BLINK;
      BLINK:   if (t == BLK_LEN_C) state_nxt = GAP;
      GAP:     if (t == GAP_LEN_C) state_nxt = grant;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      t_nxt = T_ONE_C;
      if (state_nxt == R1G || state_nxt == R2G || state_nxt == WALK) last_nxt = state_nxt;
    end
    // Entering or holding the served phase clears its request; elsewhere requests accumulate.
    pend1_nxt = (state_nxt == R1G)  ? 1'b0 : (pend1 | (bus.car1_req && state != R1G));
    pend2_nxt = (state_nxt == R2G)  ? 1'b0 : (pend2 | (bus.car2_req && state != R2G));
    pendp_nxt = (state_nxt == WALK) ? 1'b0 : (pendp | (bus.ped_req && state != WALK));
    lamp_nxt  = lamp_decode(state_nxt, ~t_nxt[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= WALK;
      t     <= T_ONE_C;
      pend1 <= 1'b0;
      pend2 <= 1'b0;
      pendp <= 1'b0;
      lamp  <= 8'b0010_0101;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      t     <= t_nxt;
      pend1 <= pend1_nxt;
      pend2 <= pend2_nxt;
      pendp <= pendp_nxt;
      lamp  <= lamp_nxt;
    end
  end

  assign bus.Road1_G  = lamp[7];
  assign bus.Road1_Y  = lamp[6];
  assign bus.Road1_R  = lamp[5];
  assign bus.Road2_G  = lamp[4];
  assign bus.Road2_Y  = lamp[3];
  assign bus.Road2_R  = lamp[2];
  assign bus.Walk_G   = lamp[1];
  assign bus.Walk_R   = lamp[0];
  assign bus.phase    = state;
  assign bus.ped_wait = pendp;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: directed scenarios queue per-cycle
// expected phase/lamp/ped_wait vectors, and a negedge monitor pops and compares them.
module tb_traffic_phase_scheduler;
  logic clk = 1'b0;
  logic rst;

  traffic_phase_scheduler_if bus();

  traffic_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] obs;
  logic        inv_bad;

  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {bus.phase, bus.Road1_G, bus.Road1_Y, bus.Road1_R,
                bus.Road2_G, bus.Road2_Y, bus.Road2_R, bus.Walk_G, bus.Walk_R, bus.ped_wait};

  assign inv_bad = (bus.Road1_G & bus.Road2_G) | (bus.Road1_Y & bus.Road2_Y) |
                   (bus.Walk_G & bus.Walk_R) |
                   ((bus.Road1_G | bus.Road1_Y | bus.Road2_G | bus.Road2_Y) & ~bus.Walk_R);

  // Expected {phase, R1G R1Y R1R R2G R2Y R2R WG WR, ped_wait} for a given phase.
  function automatic logic [11:0] ev(input logic [2:0] ph, input logic wg, input logic pw);
    logic [7:0] l;
    case (ph)
      3'd1:    l = 8'b1000_0101;
      3'd2:    l = 8'b0100_0101;
      3'd3:    l = 8'b0011_0001;
      3'd4:    l = 8'b0010_1001;
      3'd5:    l = 8'b0010_0110;
      3'd6:    l = {6'b001001, wg, 1'b0};
      default: l = 8'b0010_0101;
    endcase
    return {ph, l, pw};
  endfunction

  task automatic push(input int c, input int n, input logic [2:0] ph, input logic pw,
                      input string nm);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc  = c + i;
      e.val  = ev(ph, 1'b0, pw);
      e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic push_blink(input int c, input string nm);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.cyc  = c + i;
      e.val  = ev(3'd6, logic'(i % 2), 1'b0);
      e.name = nm;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    checks++;
    if (inv_bad !== 1'b0) begin
      errors++;
      $display("FAIL invariant cyc=%0d lamps=%03h", cyc, obs);
    end
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (obs !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%03h required=%03h", sb[i].name, cyc, obs, sb[i].val);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(output int b);
    bus.car1_req = 1'b0;
    bus.car2_req = 1'b0;
    bus.ped_req  = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    b = cyc;
  endtask

  initial begin
    int b;
    rst = 1'b1;
    bus.car1_req = 1'b0;
    bus.car2_req = 1'b0;
    bus.ped_req  = 1'b0;
    tick(2);

    // No demand: rest all-red.
    do_reset(b);
    push(b, 200, 3'd0, 1'b0, "idle_rest");
    tick(200);

    // Road1 alone rests in green.
    do_reset(b);
    bus.car1_req = 1'b1;
    push(b, 2, 3'd0, 1'b0, "r1_latency");
    push(b + 2, 150, 3'd1, 1'b0, "r1_rest_green");
    tick(152);

    // Road1 held, Road2 pulse: max green then Road2, Road2 gapped at G_MIN.
    do_reset(b);
    bus.car1_req = 1'b1;
    push(b, 2, 3'd0, 1'b0, "maxg_idle");
    push(b + 2, 40, 3'd1, 1'b0, "maxg_r1g");
    push(b + 42, 5, 3'd2, 1'b0, "maxg_r1y");
    push(b + 47, 2, 3'd7, 1'b0, "maxg_gap");
    push(b + 49, 10, 3'd3, 1'b0, "maxg_r2g");
    push(b + 59, 5, 3'd4, 1'b0, "maxg_r2y");
    push(b + 64, 2, 3'd7, 1'b0, "maxg_gap2");
    push(b + 66, 1, 3'd1, 1'b0, "maxg_r1g_again");
    tick(4);
    bus.car2_req = 1'b1;
    tick(1);
    bus.car2_req = 1'b0;
    tick(62);

    // Road1 released at green cycle 15 with Road2 pending.
    do_reset(b);
    bus.car1_req = 1'b1;
    push(b, 2, 3'd0, 1'b0, "gapout_idle");
    push(b + 2, 15, 3'd1, 1'b0, "gapout_r1g");
    push(b + 17, 5, 3'd2, 1'b0, "gapout_r1y");
    push(b + 22, 2, 3'd7, 1'b0, "gapout_gap");
    push(b + 24, 7, 3'd3, 1'b0, "gapout_r2g_rest");
    tick(4);
    bus.car2_req = 1'b1;
    tick(1);
    bus.car2_req = 1'b0;
    tick(11);
    bus.car1_req = 1'b0;
    tick(15);

    // Reset in the middle of Road2 yellow.
    do_reset(b);
    bus.car1_req = 1'b1;
    push(b + 59, 2, 3'd4, 1'b0, "rstmid_r2y");
    push(b + 61, 10, 3'd0, 1'b0, "rstmid_idle");
    tick(4);
    bus.car2_req = 1'b1;
    tick(1);
    bus.car2_req = 1'b0;
    tick(55);
    rst = 1'b1;
    bus.car1_req = 1'b0;
    tick(1);
    rst = 1'b0;
    checks++;
    if (bus.phase !== 3'd0 || bus.ped_wait !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_direct phase=%0d ped_wait=%b", bus.phase, bus.ped_wait);
    end
    tick(10);

    // Pedestrian pulse during Road1 green.
    do_reset(b);
    bus.car1_req = 1'b1;
    push(b, 2, 3'd0, 1'b0, "ped_idle");
    push(b + 2, 3, 3'd1, 1'b0, "ped_r1g_pre");
    push(b + 5, 37, 3'd1, 1'b1, "ped_r1g_wait");
    push(b + 42, 5, 3'd2, 1'b1, "ped_r1y");
    push(b + 47, 2, 3'd7, 1'b1, "ped_gap");
    push(b + 49, 26, 3'd5, 1'b0, "ped_walk");
    push_blink(b + 75, "ped_blink");
    push(b + 81, 2, 3'd7, 1'b0, "ped_gap2");
    push(b + 83, 8, 3'd1, 1'b0, "ped_r1g_back");
    tick(4);
    bus.ped_req = 1'b1;
    tick(1);
    bus.ped_req = 1'b0;
    tick(86);

`ifdef PED_PRIORITY_EN
    // Pedestrian priority: green cut at G_MIN, walk served before Road2.
    do_reset(b);
    bus.car1_req = 1'b1;
    push(b + 2, 3, 3'd1, 1'b0, "prio_r1g_pre");
    push(b + 5, 7, 3'd1, 1'b1, "prio_r1g_wait");
    push(b + 12, 5, 3'd2, 1'b1, "prio_r1y");
    push(b + 17, 2, 3'd7, 1'b1, "prio_gap");
    push(b + 19, 26, 3'd5, 1'b0, "prio_walk");
    tick(4);
    bus.car2_req = 1'b1;
    bus.ped_req  = 1'b1;
    tick(1);
    bus.car2_req = 1'b0;
    bus.ped_req  = 1'b0;
    tick(40);
`endif

    tick(2);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d actual=unchecked required=%03h", sb[i].name, sb[i].cyc, sb[i].val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
